charge_event_tracker: RTL and testbench

- Downstream consumer of the charge detector's two flag outputs (Y0, Y1).
- Treats {y1,y0} as a 2-bit charge class, debounces it, and emits one event per stable class change.
- Each event is presented on a single-entry valid/ready output with a saturating event counter and a sticky overflow flag.
- Sits between the combinational detector and the logging/display logic.

---
 rtl/charge_pkg.sv | 30 +++
 rtl/charge_debounce.sv | 55 +++++
 rtl/charge_event_tracker.sv | 92 +++++++++
 tb/tb_charge_event_tracker.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/charge_pkg.sv
// Shared definitions for the charge event tracker: class encodings, FSM states and
// the layout of the event code presented to the consumer.
package charge_pkg;

  localparam logic [1:0] CLS_NONE = 2'b00;
  localparam logic [1:0] CLS_LOW  = 2'b01;
  localparam logic [1:0] CLS_HIGH = 2'b10;
  localparam logic [1:0] CLS_BOTH = 2'b11;

  // Wide enough for the largest legal debounce length (15).
  localparam int unsigned DCNT_W = 4;

  typedef enum logic {
    ST_WAIT = 1'b0,
    ST_HOLD = 1'b1
  } evt_state_e;

  typedef struct packed {
    logic [1:0] prev_class;
    logic [1:0] new_class;
  } evt_code_t;

  function automatic evt_code_t make_code(logic [1:0] prev_class, logic [1:0] new_class);
    evt_code_t code;
    code.prev_class = prev_class;
    code.new_class  = new_class;
    return code;
  endfunction

endpackage

// File: rtl/charge_debounce.sv
// Registers the detector class, requires DEBOUNCE identical samples before accepting
// it, and strobes accept for exactly one cycle per accepted class change.
module charge_debounce
  import charge_pkg::*;
#(
  parameter int unsigned DEBOUNCE = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] cls,
  output logic       accept,
  output logic [1:0] cand,
  output logic [1:0] stable_class
);

  localparam logic [DCNT_W-1:0] DMax = DCNT_W'(DEBOUNCE);

  logic [1:0]        samp_q;
  logic [1:0]        cand_q, cand_d;
  logic [DCNT_W-1:0] dcnt_q, dcnt_d;
  logic [1:0]        stable_q, stable_d;

  always_comb begin
    cand_d = cand_q;
    dcnt_d = dcnt_q;
    if (samp_q != cand_q) begin
      cand_d = samp_q;
      dcnt_d = DCNT_W'(1);
    end else if (dcnt_q < DMax) begin
      dcnt_d = dcnt_q + DCNT_W'(1);
    end
  end

  // Once accepted, cand equals stable_class, so the strobe cannot repeat.
  assign accept   = (dcnt_q == DMax) && (cand_q != stable_q);
  assign stable_d = accept ? cand_q : stable_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      samp_q   <= CLS_NONE;
      cand_q   <= CLS_NONE;
      dcnt_q   <= '0;
      stable_q <= CLS_NONE;
    end else begin
      samp_q   <= cls;
      cand_q   <= cand_d;
      dcnt_q   <= dcnt_d;
      stable_q <= stable_d;
    end
  end

  assign cand         = cand_q;
  assign stable_class = stable_q;

endmodule

// File: rtl/charge_event_tracker.sv
// Turns debounced charge-class changes into single-entry valid/ready events with a
// saturating event counter and a sticky overflow flag for dropped events.
module charge_event_tracker
  import charge_pkg::*;
#(
  parameter int unsigned DEBOUNCE = 4,
  parameter int unsigned CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             y0,
  input  logic             y1,
  input  logic             evt_ready,
  input  logic             clr_ovf,
  output logic             evt_valid,
  output logic [3:0]       evt_code,
  output logic [CNT_W-1:0] evt_count,
  output logic             overflow,
  output logic [1:0]       stable_class
);

  logic       accept;
  logic [1:0] cand;

  charge_debounce #(
    .DEBOUNCE(DEBOUNCE)
  ) u_debounce (
    .clk         (clk),
    .rst         (rst),
    .cls         ({y1, y0}),
    .accept      (accept),
    .cand        (cand),
    .stable_class(stable_class)
  );

  evt_state_e       state_q, state_d;
  evt_code_t        code_q, code_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             load, drop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_WAIT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_WAIT: if (accept) state_d = ST_HOLD;
      ST_HOLD: if (evt_ready && !accept) state_d = ST_WAIT;
    endcase
  end

  // A detection in HOLD is only kept when the held event leaves on the same edge.
  assign load = accept && ((state_q == ST_WAIT) || evt_ready);
  assign drop = accept && (state_q == ST_HOLD) && !evt_ready;

  always_comb begin
    code_d = load ? make_code(stable_class, cand) : code_q;
    cnt_d  = (accept && (cnt_q != '1)) ? cnt_q + CNT_W'(1) : cnt_q;
    ovf_d  = ovf_q;
    if (drop) begin
      ovf_d = 1'b1;
    end else if (clr_ovf) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      code_q <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      code_q <= code_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
    end
  end

  always_comb begin
    evt_valid = (state_q == ST_HOLD);
    evt_code  = code_q;
    evt_count = cnt_q;
    overflow  = ovf_q;
  end

endmodule

// File: tb/tb_charge_event_tracker.sv
// Randomised scoreboard bench: a window-based reference model predicts events, counts
// and flags; a negedge monitor compares both DUT instances against it.
module tb_charge_event_tracker;

  localparam int unsigned D = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       y0, y1, evt_ready, clr_ovf;

  logic       valid_a, ovf_a;
  logic [3:0] code_a;
  logic [7:0] cnt_a;
  logic [1:0] stable_a;

  logic       valid_b, ovf_b;
  logic [3:0] code_b;
  logic [1:0] cnt_b;
  logic [1:0] stable_b;

  charge_event_tracker #(.DEBOUNCE(D), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .y0(y0), .y1(y1), .evt_ready(evt_ready), .clr_ovf(clr_ovf),
    .evt_valid(valid_a), .evt_code(code_a), .evt_count(cnt_a), .overflow(ovf_a),
    .stable_class(stable_a)
  );

  charge_event_tracker #(.DEBOUNCE(D), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .y0(y0), .y1(y1), .evt_ready(evt_ready), .clr_ovf(clr_ovf),
    .evt_valid(valid_b), .evt_code(code_b), .evt_count(cnt_b), .overflow(ovf_b),
    .stable_class(stable_b)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state.
  logic [1:0] hist[$];
  logic [3:0] exp_q[$];
  bit         held_m;
  bit         ovf_m;
  logic [1:0] stable_m;
  int         cnt_m;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < D + 1; i++) hist.push_back(2'b00);
    exp_q.delete();
    held_m   = 0;
    ovf_m    = 0;
    stable_m = 2'b00;
    cnt_m    = 0;
  endtask

  // A class is detected at an edge when the D samples captured two or more edges
  // earlier all agree on it and it differs from the accepted class.
  task automatic model_edge(input logic [1:0] cls, input bit rdy, input bit clr);
    bit         hs, det, drop;
    logic [1:0] c, old;
    int         n;
    n    = hist.size();
    hs   = held_m && rdy;
    c    = hist[n-2];
    det  = (c != stable_m);
    drop = 0;
    for (int k = 2; k <= D + 1; k++) if (hist[n-k] != c) det = 0;
    if (det) begin
      old      = stable_m;
      stable_m = c;
      if (cnt_m < 255) cnt_m++;
      if (!held_m || hs) begin
        exp_q.push_back({old, c});
        held_m = 1;
      end else begin
        drop  = 1;
        ovf_m = 1;
      end
    end else if (hs) begin
      held_m = 0;
    end
    if (!drop && clr) ovf_m = 0;
    hist.push_back(cls);
    if (hist.size() > 40) void'(hist.pop_front());
  endtask

  task automatic step(input logic [1:0] cls, input bit rdy, input bit clr);
    {y1, y0}  = cls;
    evt_ready = rdy;
    clr_ovf   = clr;
    @(posedge clk);
    model_edge(cls, rdy, clr);
    #1;
  endtask

  task automatic hold(input logic [1:0] cls, input bit rdy, input int n);
    for (int i = 0; i < n; i++) step(cls, rdy, 1'b0);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      chk("evt_valid", valid_a, held_m);
      chk("evt_count", cnt_a, cnt_m);
      chk("overflow", ovf_a, ovf_m);
      chk("stable_class", stable_a, stable_m);
      chk("evt_valid_w2", valid_b, held_m);
      chk("evt_count_sat", cnt_b, (cnt_m > 3) ? 3 : cnt_m);
      if (valid_a) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL scoreboard: got event %0h expected none at %0t", code_a, $time);
        end else begin
          chk("evt_code", code_a, exp_q[0]);
          chk("evt_code_w2", code_b, exp_q[0]);
          if (evt_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    {y1, y0} = 2'b00;
    evt_ready = 1'b0;
    clr_ovf   = 1'b0;
    model_reset();
    #2;
    chk("reset_valid", valid_a, 0);
    chk("reset_count", cnt_a, 0);
    chk("reset_stable", stable_a, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Clean change with the consumer ready, then a 3-sample glitch.
    hold(2'b00, 1'b1, 3);
    hold(2'b01, 1'b1, 9);
    hold(2'b10, 1'b1, 3);
    hold(2'b01, 1'b1, 8);

    // Backpressure: first event held, second dropped, then overflow cleared.
    hold(2'b00, 1'b0, 8);
    hold(2'b11, 1'b0, 8);
    step(2'b11, 1'b0, 1'b1);
    hold(2'b11, 1'b0, 2);

    // Handshake coincides with a detection: new event replaces the held one.
    hold(2'b01, 1'b0, 5);
    step(2'b01, 1'b1, 1'b0);
    hold(2'b01, 1'b0, 3);
    hold(2'b01, 1'b1, 2);

    // Asynchronous reset while an event is held.
    hold(2'b10, 1'b0, 8);
    chk("pre_reset_valid", valid_a, 1);
    #2 rst = 1'b1;
    #1;
    chk("async_valid", valid_a, 0);
    chk("async_code", code_a, 0);
    chk("async_count", cnt_a, 0);
    chk("async_overflow", ovf_a, 0);
    chk("async_stable", stable_a, 0);
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;

    for (int r = 0; r < 300; r++) begin
      logic [1:0] cls;
      int         len;
      cls = 2'($urandom_range(0, 3));
      len = $urandom_range(1, 7);
      for (int j = 0; j < len; j++)
        step(cls, ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0));
    end

    hold(2'b00, 1'b1, 12);
    chk("final_valid", valid_a, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
